// File: rtl/sprite_banner_if.sv
// Pixel, control and ROM signals of the sprite_banner overlay, bundled with
// a master (pipeline/driver) and slave (overlay) view.
interface sprite_banner_if #(
  parameter int FRAMES = 2,
  parameter int ROM_AW = 15
);
  localparam int SEL_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  logic [9:0]          h_line;
  logic [9:0]          v_line;
  logic                valid_in;
  logic                frame_start;
  logic                show;
  logic                blink_en;
  logic [SEL_W-1:0]    frame_sel;
  logic [ROM_AW-1:0]   rom_addr;
  logic [4*FRAMES-1:0] rom_data;
  logic                valid_out;
  logic [23:0]         color_out;
  logic                busy;

  modport master (
    output h_line, v_line, valid_in, frame_start, show, blink_en, frame_sel, rom_data,
    input  rom_addr, valid_out, color_out, busy
  );

  modport slave (
    input  h_line, v_line, valid_in, frame_start, show, blink_en, frame_sel, rom_data,
    output rom_addr, valid_out, color_out, busy
  );
endinterface

// File: rtl/sprite_banner.sv
// Animated sprite overlay: slides a ROM-backed banner in from below, holds it
// and optionally blinks it; emits opaque pixels as 24-bit RGB two cycles later.
module sprite_banner #(
  parameter int SPR_W        = 198,
  parameter int SPR_H        = 54,
  parameter int POS_H        = 340,
  parameter int POS_V        = 296,
  parameter int FRAMES       = 2,
  parameter int ROM_AW       = 15,
  parameter int ROM_BASE     = 1,
  parameter int SLIDE_DIST   = 64,
  parameter int SLIDE_STEP   = 4,
  parameter int BLINK_FRAMES = 30
) (
  input logic            clk,
  input logic            rst,
  sprite_banner_if.slave bus
);
  localparam int SEL_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [10:0]      START_V  = 11'(POS_V + SLIDE_DIST);
  localparam logic [10:0]      FINAL_V  = 11'(POS_V);
  localparam logic [10:0]      SNAP_V   = 11'(POS_V + SLIDE_STEP);
  localparam logic [10:0]      STEP_V   = 11'(SLIDE_STEP);
  localparam logic [10:0]      H_LO     = 11'(POS_H);
  localparam logic [10:0]      H_HI     = 11'(POS_H + SPR_W - 1);
  localparam logic [10:0]      V_SPAN   = 11'(SPR_H - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [31:0]      FRAMES_U = 32'(FRAMES);

  typedef enum logic [1:0] {IDLE = 2'd0, SLIDE = 2'd1, HOLD = 2'd2} st_t;

  st_t              st_r, st_nx_s;
  logic [10:0]      cur_v_r, cur_v_nx_s;
  logic [CNT_W-1:0] blink_cnt_r, blink_cnt_nx_s;
  logic             blank_r, blank_nx_s;
  logic             busy_r;
  logic [10:0]      h_ext_s, v_ext_s, v_bot_s;
  logic             hit_s;
  logic [15:0]      addr_s;
  logic             s1_hit_r;
  logic [SEL_W-1:0] s1_sel_r;
  logic [3:0]       nib_s;
  logic             valid_r;
  logic [23:0]      color_r;

  function automatic logic [23:0] palette(input logic [3:0] n);
    case (n)
      4'd9:    palette = 24'hFFFFFF;
      4'd10:   palette = 24'h58D858;
      4'd11:   palette = 24'h00A848;
      4'd12:   palette = 24'hFCA048;
      4'd13:   palette = 24'hE46018;
      4'd14:   palette = 24'hFCD8A8;
      default: palette = 24'h000000;
    endcase
  endfunction

  // Animation state register; busy follows the next state so it tracks st with no lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_r        <= IDLE;
      cur_v_r     <= START_V;
      blink_cnt_r <= {CNT_W{1'b0}};
      blank_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      st_r        <= st_nx_s;
      cur_v_r     <= cur_v_nx_s;
      blink_cnt_r <= blink_cnt_nx_s;
      blank_r     <= blank_nx_s;
      busy_r      <= (st_nx_s != IDLE);
    end
  end

  // Next-state logic; everything moves only on frame_start so a frame never tears.
  always_comb begin
    st_nx_s        = st_r;
    cur_v_nx_s     = cur_v_r;
    blink_cnt_nx_s = blink_cnt_r;
    blank_nx_s     = blank_r;
    if (bus.frame_start) begin
      case (st_r)
        IDLE: begin
          if (bus.show) begin
            st_nx_s = SLIDE;
          end else begin
            st_nx_s = IDLE;
          end
        end
        SLIDE: begin
          if (!bus.show) begin
            st_nx_s    = IDLE;
            cur_v_nx_s = START_V;
          end else if (cur_v_r <= SNAP_V) begin
            st_nx_s    = HOLD;
            cur_v_nx_s = FINAL_V;
          end else begin
            cur_v_nx_s = cur_v_r - STEP_V;
          end
        end
        HOLD: begin
          if (!bus.show) begin
            st_nx_s        = IDLE;
            cur_v_nx_s     = START_V;
            blink_cnt_nx_s = {CNT_W{1'b0}};
            blank_nx_s     = 1'b0;
          end else if (bus.blink_en) begin
            if (blink_cnt_r == CNT_LAST) begin
              blink_cnt_nx_s = {CNT_W{1'b0}};
              blank_nx_s     = ~blank_r;
            end else begin
              blink_cnt_nx_s = blink_cnt_r + CNT_W'(1);
            end
          end else begin
            blink_cnt_nx_s = {CNT_W{1'b0}};
            blank_nx_s     = 1'b0;
          end
        end
        default: begin
          st_nx_s    = IDLE;
          cur_v_nx_s = START_V;
        end
      endcase
    end else begin
      st_nx_s = st_r;
    end
  end

  // 11-bit compares keep cur_v + SPR_H from wrapping; rows are stored bottom-up.
  assign h_ext_s = {1'b0, bus.h_line};
  assign v_ext_s = {1'b0, bus.v_line};
  assign v_bot_s = cur_v_r + V_SPAN;
  assign hit_s   = (st_r != IDLE) && !blank_r &&
                   (h_ext_s >= H_LO) && (h_ext_s <= H_HI) &&
                   (v_ext_s >= cur_v_r) && (v_ext_s <= v_bot_s);
  assign addr_s  = 16'(ROM_BASE) + (16'(h_ext_s) - 16'(POS_H)) +
                   16'(SPR_W) * (16'(v_bot_s) - 16'(v_ext_s));
  assign bus.rom_addr = hit_s ? ROM_AW'(addr_s) : ROM_AW'(ROM_BASE);

  assign nib_s = bus.rom_data[{s1_sel_r, 2'b00} +: 4];

  // Two-stage pixel pipeline aligned with the ROM's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hit_r <= 1'b0;
      s1_sel_r <= {SEL_W{1'b0}};
      valid_r  <= 1'b0;
      color_r  <= 24'h000000;
    end else begin
      s1_hit_r <= hit_s & bus.valid_in;
      s1_sel_r <= (32'(bus.frame_sel) >= FRAMES_U) ? {SEL_W{1'b0}} : bus.frame_sel;
      valid_r  <= s1_hit_r & nib_s[3];
      if (s1_hit_r & nib_s[3]) begin
        color_r <= palette(nib_s);
      end else begin
        color_r <= color_r;
      end
    end
  end

  assign bus.valid_out = valid_r;
  assign bus.color_out = color_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_sprite_banner.sv
// Randomised bench for sprite_banner: a frame-level behavioural model predicts
// rom_addr, busy and the two-cycle-delayed pixel outputs every cycle.
module tb_sprite_banner;
  localparam int SPR_W = 198, SPR_H = 54, POS_H = 340, POS_V = 296;
  localparam int FRAMES = 2, ROM_AW = 15, ROM_BASE = 1;
  localparam int SLIDE_DIST = 64, SLIDE_STEP = 4, BF = 30;
  localparam int START_V = POS_V + SLIDE_DIST;
  localparam logic [23:0] PAL [0:7] = '{24'h000000, 24'hFFFFFF, 24'h58D858, 24'h00A848,
                                        24'hFCA048, 24'hE46018, 24'hFCD8A8, 24'h000000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  sprite_banner_if #(.FRAMES(FRAMES), .ROM_AW(ROM_AW)) bus ();
  sprite_banner dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] rom_mem [0:(1<<ROM_AW)-1];
  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  // model: animation phase, banner top row, blink-enabled hold frames
  int          m_st = 0;
  int          m_cur_v = START_V;
  int          m_blink_n = 0;
  bit          p1v = 1'b0, p2v = 1'b0;
  logic [23:0] p1c = 24'h0, p2c = 24'h0;

  task automatic chk(string name, longint got, longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit m_blank();
    return ((m_blink_n / BF) % 2) == 1;
  endfunction

  task automatic frame_update();
    case (m_st)
      0: if (bus.show) m_st = 1;
      1: begin
        if (!bus.show) begin
          m_st = 0; m_cur_v = START_V;
        end else if (m_cur_v - SLIDE_STEP <= POS_V) begin
          m_st = 2; m_cur_v = POS_V;
        end else begin
          m_cur_v = m_cur_v - SLIDE_STEP;
        end
      end
      2: begin
        if (!bus.show) begin
          m_st = 0; m_cur_v = START_V; m_blink_n = 0;
        end else if (bus.blink_en) begin
          m_blink_n++;
        end else begin
          m_blink_n = 0;
        end
      end
      default: m_st = 0;
    endcase
  endtask

  always @(negedge clk) begin : compare
    int h, v, addr, sel, nib;
    bit hit, nv;
    logic [23:0] nc;
    h = int'(bus.h_line);
    v = int'(bus.v_line);
    hit = (m_st != 0) && !m_blank() && h >= POS_H && h <= POS_H + SPR_W - 1 &&
          v >= m_cur_v && v <= m_cur_v + SPR_H - 1;
    addr = hit ? ((ROM_BASE + (h - POS_H) + SPR_W * (m_cur_v + SPR_H - 1 - v)) % (1 << ROM_AW))
               : ROM_BASE;
    chk("valid_out", bus.valid_out, p2v);
    chk("color_out", bus.color_out, p2c);
    chk("busy", bus.busy, m_st != 0);
    chk("rom_addr", bus.rom_addr, addr);
    sel = (int'(bus.frame_sel) >= FRAMES) ? 0 : int'(bus.frame_sel);
    nib = (int'(rom_mem[addr]) >> (4 * sel)) & 15;
    nv  = hit && bus.valid_in && nib >= 8;
    nc  = nv ? PAL[nib & 7] : p1c;
    if (rst) begin
      p1v = 1'b0; p2v = 1'b0; p1c = 24'h0; p2c = 24'h0;
      m_st = 0; m_cur_v = START_V; m_blink_n = 0;
    end else begin
      p2v = p1v; p2c = p1c; p1v = nv; p1c = nc;
      if (bus.frame_start) frame_update();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(int h, int v, int sel, bit vin);
    bus.h_line   = 10'(h);
    bus.v_line   = 10'(v);
    bus.frame_sel = 1'(sel);
    bus.valid_in = vin;
  endtask

  task automatic rand_pix();
    pix($urandom_range(330, 545), $urandom_range(280, 420), $urandom_range(0, 1),
        $urandom_range(0, 7) != 0);
  endtask

  task automatic frame(int len);
    bus.frame_start = 1'b0;
    repeat (len) begin rand_pix(); step(); end
    rand_pix();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
  endtask

  // drive one pixel, idle a cycle, then check the delayed output
  task automatic probe(int h, int v, int sel, bit ev, logic [23:0] ec, string nm);
    pix(h, v, sel, 1'b1);
    step();
    pix(0, 0, 0, 1'b0);
    step();
    @(negedge clk);
    chk({nm, "_valid"}, bus.valid_out, ev);
    if (ev) chk({nm, "_color"}, bus.color_out, ec);
    step();
  endtask

  task automatic addr_at(int h, int v, int ea, string nm);
    pix(h, v, 0, 1'b1);
    @(negedge clk);
    chk(nm, bus.rom_addr, ea);
    step();
  endtask

  initial begin
    for (int i = 0; i < (1 << ROM_AW); i++) rom_mem[i] = 8'($urandom);
    rom_mem[1] = 8'h9A;
    rom_mem[2] = 8'h07;
    bus.frame_start = 1'b0; bus.show = 1'b0; bus.blink_en = 1'b0;
    pix(400, 320, 0, 1'b1);

    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", bus.valid_out, 0);
      chk("rst_color", bus.color_out, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_addr", bus.rom_addr, 1);
      step();
    end
    rst = 1'b0;

    bus.show = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      frame($urandom_range(3, 6));
      chk("slide_cur_v", m_cur_v, (k == 17) ? 296 : 360 - 4 * (k - 1));
    end
    chk("slide_hold", m_st, 2);
    @(negedge clk);
    chk("hold_busy", bus.busy, 1);
    step();

    addr_at(340, 349, 1, "addr_origin");
    addr_at(537, 296, 10692, "addr_corner");
    probe(340, 349, 0, 1'b1, 24'h58D858, "lat_sel0");
    probe(340, 349, 1, 1'b1, 24'hFFFFFF, "lat_sel1");
    probe(341, 349, 0, 1'b0, 24'h0, "transp_sel0");
    probe(341, 349, 1, 1'b0, 24'h0, "transp_sel1");
    probe(538, 349, 0, 1'b0, 24'h0, "h_beyond");
    probe(340, 295, 0, 1'b0, 24'h0, "v_above");

    bus.blink_en = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      frame(2);
      if (k == 29 || k == 60) probe(340, 349, 0, 1'b1, 24'h58D858, "blink_on");
      if (k == 30 || k == 59 || k == 90) probe(340, 349, 0, 1'b0, 24'h0, "blink_off");
    end
    bus.blink_en = 1'b0;
    frame(2);
    probe(340, 349, 0, 1'b1, 24'h58D858, "blink_clear");

    bus.show = 1'b0;
    frame(2);
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    step();
    bus.show = 1'b1;
    for (int k = 1; k <= 6; k++) frame(2);
    chk("abort_cur_v", m_cur_v, 340);
    bus.show = 1'b0;
    probe(340, 393, 0, 1'b1, 24'h58D858, "abort_still");
    frame(2);
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_reset_v", m_cur_v, 360);
    step();
    bus.show = 1'b1;
    frame(2);
    probe(340, 413, 0, 1'b1, 24'h58D858, "restart_top");
    probe(340, 359, 0, 1'b0, 24'h0, "restart_above");

    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0) bus.show = ~bus.show;
      if ($urandom_range(0, 9) == 0) bus.blink_en = ~bus.blink_en;
      frame($urandom_range(1, 30));
      if ($urandom_range(0, 11) == 0) begin
        rst = 1'b1; rand_pix(); step();
        rst = 1'b0;
      end
    end
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
